// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that shares one external register among NUM_REQ requesters.
// Optional burst locking is built only when ARB_LOCK_EN is defined.
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_LOCK = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  input  logic [NUM_REQ-1:0]       lock,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         reg_d,
  output logic                     reg_load,
  output logic                     busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ARB_LOCK_EN
  typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;
`else
  typedef enum logic [1:0] {StIdle, StGrant} state_e;
`endif

  state_e               state_q, state_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]     reg_d_q, reg_d_d;
  logic                 load_q, load_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  int unsigned          idx;
  int unsigned          win;
  int unsigned          win_next;
  logic [PtrW-1:0]      win_p;

`ifdef ARB_LOCK_EN
  logic [3:0]           cnt_q, cnt_d;
  int unsigned          cur;
  logic [PtrW-1:0]      cur_p;
  logic                 lock_win;
`else
  logic                 unused_sigs;
  assign unused_sigs = ^{lock, state_q};
`endif

  // The currently granted requester is masked so nobody wins twice in a row.
  always_comb begin
    cand  = req & ~gnt_q;
    found = 1'b0;
    idx   = 0;
    win   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[PtrW'(idx)]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_p    = PtrW'(win);
    win_next = (win + 1 == NUM_REQ) ? 0 : win + 1;
  end

`ifdef ARB_LOCK_EN
  always_comb begin
    cur = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) cur = i;
    end
    cur_p    = PtrW'(cur);
    lock_win = (state_q != StIdle) && req[cur_p] && lock[cur_p] &&
               ((32'(cnt_q) + 32'd1) < MAX_LOCK);
  end
`endif

  always_comb begin
    state_d = StIdle;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    reg_d_d = reg_d_q;
    load_d  = 1'b0;
`ifdef ARB_LOCK_EN
    cnt_d   = '0;
    if (lock_win) begin
      // Locked requester keeps the register; ptr stays put so the burst end resumes fairly.
      state_d = StLocked;
      gnt_d   = gnt_q;
      reg_d_d = wdata[cur*WIDTH +: WIDTH];
      load_d  = 1'b1;
      cnt_d   = cnt_q + 4'd1;
    end else
`endif
    if (found) begin
      state_d        = StGrant;
      gnt_d[win_p]   = 1'b1;
      reg_d_d        = wdata[win*WIDTH +: WIDTH];
      load_d         = 1'b1;
      ptr_d          = PtrW'(win_next);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      reg_d_q <= '0;
      load_q  <= 1'b0;
`ifdef ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      reg_d_q <= reg_d_d;
      load_q  <= load_d;
`ifdef ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign reg_d    = reg_d_q;
  assign reg_load = load_q;
  assign busy     = |gnt_q;

endmodule
